// File: rtl/bin_decode_scheduler.sv
// Scheduler between the command/byte stream and the arithmetic decoder core.
// Optional stall counter port enabled by defining BDS_STALL_CNT_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a command, cmd_ready high
// S_RUN  | stepping the core, stalls while a needed byte is missing
// S_DONE | one-cycle done pulse, then back to S_IDLE
module bin_decode_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_bypass,
  input  logic             cmd_dual,
  input  logic [CNT_W-1:0] cmd_nbins,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [7:0]       src_byte,
  output logic             dec_en,
  output logic             dec_bypass,
  output logic             dec_n_bin,
  output logic [7:0]       dec_byte,
  input  logic             dec_byte_req,
  input  logic [1:0]       dec_bin,
  output logic [1:0]       bin_out,
  output logic [1:0]       bin_num,
  output logic             busy,
  output logic             done,
`ifdef BDS_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_count,
`endif
  output logic [CNT_W-1:0] cyc_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dual_q, dual_d;
  logic             bypass_q, bypass_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             noop_q, noop_d;
  logic [1:0]       bin_out_q, bin_out_d;
  logic [1:0]       bin_num_q, bin_num_d;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             run;
  logic             accept;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             step_two;
  logic [CNT_W-1:0] step;

  assign run        = (state_q == S_RUN);
  assign fifo_empty = (cnt_q == '0);
  assign src_ready  = (cnt_q < CW'(FIFO_DEPTH));
  assign cmd_ready  = (state_q == S_IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign step_two   = dual_q & (rem_q >= CNT_W'(2));
  assign step       = step_two ? CNT_W'(2) : CNT_W'(1);

  assign dec_en     = run & ~(dec_byte_req & fifo_empty);
  assign dec_n_bin  = run & step_two;
  assign dec_bypass = run & bypass_q;
  assign busy       = run;
  assign done       = (state_q == S_DONE) | noop_q;
  assign cyc_count  = cyc_q;
  assign bin_out    = bin_out_q;
  assign bin_num    = bin_num_q;

  // Push and pop share a cycle without freeing space early: src_ready uses cnt_q.
  assign push     = src_valid & src_ready;
  assign pop      = dec_en & dec_byte_req;
  assign dec_byte = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dual_d   = dual_q;
    bypass_d = bypass_q;
    cyc_d    = cyc_q;
    noop_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_nbins == '0) begin
            noop_d = 1'b1;
          end else begin
            state_d  = S_RUN;
            rem_d    = cmd_nbins;
            dual_d   = cmd_dual;
            bypass_d = cmd_bypass;
            cyc_d    = '0;
          end
        end
      end
      S_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
        if (dec_en) begin
          rem_d = rem_q - step;
          if (rem_q == step) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bin_num_d = 2'd0;
    bin_out_d = bin_out_q;
    if (dec_en) begin
      bin_num_d = step_two ? 2'd2 : 2'd1;
      bin_out_d = dec_bin;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      dual_q    <= 1'b0;
      bypass_q  <= 1'b0;
      cyc_q     <= '0;
      noop_q    <= 1'b0;
      bin_out_q <= 2'd0;
      bin_num_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dual_q    <= dual_d;
      bypass_q  <= bypass_d;
      cyc_q     <= cyc_d;
      noop_q    <= noop_d;
      bin_out_q <= bin_out_d;
      bin_num_q <= bin_num_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= src_byte;
    end
  end

`ifdef BDS_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if (run && !dec_en && stall_q != '1) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_bin_decode_scheduler.sv
// Self-checking bench for bin_decode_scheduler: command table, cycle model with
// bin/byte scoreboards, and hand-written stall, saturation and reset sequences.
module tb_bin_decode_scheduler;

  localparam int CNT_W = 7;
  localparam int CMAX  = 127;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_bypass = 1'b0;
  logic             cmd_dual = 1'b0;
  logic [CNT_W-1:0] cmd_nbins = '0;
  logic             src_valid = 1'b0;
  logic             src_ready;
  logic [7:0]       src_byte = 8'h00;
  logic             dec_en;
  logic             dec_bypass;
  logic             dec_n_bin;
  logic [7:0]       dec_byte;
  logic             dec_byte_req = 1'b0;
  logic [1:0]       dec_bin = 2'd0;
  logic [1:0]       bin_out;
  logic [1:0]       bin_num;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] cyc_count;
`ifdef BDS_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count;
`endif

  bin_decode_scheduler #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bypass(cmd_bypass),
    .cmd_dual(cmd_dual), .cmd_nbins(cmd_nbins),
    .src_valid(src_valid), .src_ready(src_ready), .src_byte(src_byte),
    .dec_en(dec_en), .dec_bypass(dec_bypass), .dec_n_bin(dec_n_bin),
    .dec_byte(dec_byte), .dec_byte_req(dec_byte_req), .dec_bin(dec_bin),
    .bin_out(bin_out), .bin_num(bin_num), .busy(busy), .done(done),
`ifdef BDS_STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .cyc_count(cyc_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0] bin;
    logic [1:0] num;
  } bin_t;

  bin_t       binq[$];
  logic [7:0] bq[$];
  int         m_state = 0;
  int         m_rem = 0;
  bit         m_dual = 0;
  bit         m_byp = 0;
  int         m_cyc = 0;
  int         m_stall = 0;
  bit         m_noop = 0;

  // Random core bins each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1 dec_bin = 2'($urandom_range(0, 3));
    end
  end

  always @(negedge clk) begin
    bin_t       b;
    bit         e_empty, e_en, e_push, e_pop, acc;
    int         step;
    logic [7:0] e_byte;
    if (!reset) begin
      m_state = 0; m_rem = 0; m_dual = 0; m_byp = 0;
      m_cyc = 0; m_stall = 0; m_noop = 0;
      bq.delete();
      binq.delete();
    end else begin
      if (binq.size() > 0) begin
        b = binq.pop_front();
        chk("bin_num", 32'(bin_num), 32'(b.num));
        chk("bin_out", 32'(bin_out), 32'(b.bin));
      end else begin
        chk("bin_num_idle", 32'(bin_num), 32'd0);
      end
      e_empty = (bq.size() == 0);
      e_en    = (m_state == 1) && !(dec_byte_req && e_empty);
      step    = (m_dual && m_rem >= 2) ? 2 : 1;
      e_byte  = e_empty ? 8'h00 : bq[0];
      chk("ctrl", 32'({cmd_ready, busy, done, src_ready, dec_en, dec_n_bin, dec_bypass}),
          32'({m_state == 0, m_state == 1, (m_state == 2) || m_noop, bq.size() < 4,
               e_en, (m_state == 1) && step == 2, (m_state == 1) && m_byp}));
      chk("dec_byte", 32'(dec_byte), 32'(e_byte));
      chk("cyc_count", 32'(cyc_count), 32'(m_cyc));
`ifdef BDS_STALL_CNT_EN
      chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
      if (dec_en) en_cnt++;
      if (e_en) binq.push_back('{bin: dec_bin, num: 2'(step)});

      acc    = cmd_valid && (m_state == 0);
      e_push = src_valid && (bq.size() < 4);
      e_pop  = e_en && dec_byte_req;
      if (e_pop) void'(bq.pop_front());
      if (e_push) bq.push_back(src_byte);
      m_noop = 0;
      case (m_state)
        0: if (acc) begin
          m_stall = 0;
          if (cmd_nbins == 0) m_noop = 1;
          else begin
            m_state = 1; m_rem = int'(cmd_nbins); m_dual = cmd_dual;
            m_byp = cmd_bypass; m_cyc = 0;
          end
        end
        1: begin
          if (m_cyc < CMAX) m_cyc++;
          if (!e_en && m_stall < CMAX) m_stall++;
          if (e_en) begin
            m_rem -= step;
            if (m_rem == 0) m_state = 2;
          end
        end
        default: m_state = 0;
      endcase
    end
  end

  task automatic push_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      src_valid = 1'b1;
      src_byte  = base + 8'(i);
    end
    @(posedge clk); #1;
    src_valid = 1'b0;
  endtask

  task automatic issue_cmd(input int nb, input bit dual, input bit byp);
    @(posedge clk); #1;
    for (int i = 0; i < 300 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_nbins  = CNT_W'(nb);
    cmd_dual   = dual;
    cmd_bypass = byp;
    en_cnt     = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("done_timeout", 32'(seen), 32'd1);
  endtask

  typedef struct {
    int nbins;
    bit dual;
    bit byp;
    bit req;
    int steps;
    int cyc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{nbins: 5,   dual: 0, byp: 0, req: 0, steps: 5,  cyc: 5};
    tbl[1] = '{nbins: 5,   dual: 1, byp: 1, req: 0, steps: 3,  cyc: 3};
    tbl[2] = '{nbins: 0,   dual: 1, byp: 0, req: 0, steps: 0,  cyc: 3};
    tbl[3] = '{nbins: 4,   dual: 1, byp: 0, req: 1, steps: 2,  cyc: 2};
    tbl[4] = '{nbins: 2,   dual: 0, byp: 1, req: 1, steps: 2,  cyc: 2};
    tbl[5] = '{nbins: 1,   dual: 1, byp: 0, req: 0, steps: 1,  cyc: 1};
    tbl[6] = '{nbins: 7,   dual: 1, byp: 0, req: 0, steps: 4,  cyc: 4};
    tbl[7] = '{nbins: 127, dual: 1, byp: 0, req: 0, steps: 64, cyc: 64};

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_src_ready", 32'(src_ready), 32'd1);
    chk("rst_outs", 32'({busy, done, dec_en, dec_n_bin, dec_bypass, bin_num, bin_out}), 32'd0);
    chk("rst_byte_cyc", 32'({dec_byte, cyc_count}), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Fill to four, then a fifth offer must be refused.
    push_bytes(4, 8'hA0);
    @(negedge clk);
    chk("full_src_ready", 32'(src_ready), 32'd0);
    push_bytes(1, 8'hEE);

    for (int i = 0; i < 8; i++) begin
      dec_byte_req = tbl[i].req;
      issue_cmd(tbl[i].nbins, tbl[i].dual, tbl[i].byp);
      if (tbl[i].nbins == 0) begin
        @(negedge clk);
        chk("noop_done", 32'({done, cmd_ready}), 32'b11);
      end else begin
        wait_done(300);
      end
      chk($sformatf("steps[%0d]", i), 32'(en_cnt), 32'(tbl[i].steps));
      chk($sformatf("cyc[%0d]", i), 32'(cyc_count), 32'(tbl[i].cyc));
      dec_byte_req = 1'b0;
    end

    // Stall on an empty FIFO; a byte pushed in cycle 4 is consumed in cycle 5.
    dec_byte_req = 1'b1;
    issue_cmd(2, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_en", 32'(dec_en), 32'd0);
    end
    @(posedge clk); #1;
    src_valid = 1'b1; src_byte = 8'h5A;
    @(negedge clk);
    chk("stall_push_cycle_en", 32'(dec_en), 32'd0);
    @(posedge clk); #1;
    src_valid = 1'b0;
    @(negedge clk);
    chk("stall_pop_en", 32'({dec_en, dec_byte}), 32'h15A);
    @(negedge clk);
    chk("stall_again_en", 32'({dec_en, dec_byte}), 32'h000);
    @(posedge clk); #1;
    src_valid = 1'b1; src_byte = 8'h5B;
    @(posedge clk); #1;
    src_valid = 1'b0;
    wait_done(20);
    chk("stall_cyc", 32'(cyc_count), 32'd8);
`ifdef BDS_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_count), 32'd6);
`endif
    dec_byte_req = 1'b0;

    // Push and pop together at count 3.
    push_bytes(3, 8'h40);
    dec_byte_req = 1'b1;
    issue_cmd(1, 0, 0);
    src_valid = 1'b1; src_byte = 8'h50;
    @(negedge clk);
    chk("pp_cycle", 32'({dec_en, src_ready, dec_byte}), 32'h340);
    @(posedge clk); #1;
    src_byte = 8'h51;
    @(negedge clk);
    chk("pp_count3_ready", 32'(src_ready), 32'd1);
    @(posedge clk); #1;
    src_valid = 1'b0;
    @(negedge clk);
    chk("pp_full_ready", 32'(src_ready), 32'd0);

    // Bytes persist across commands: drain 41,42,50,51 in order.
    issue_cmd(4, 0, 0);
    wait_done(20);
    chk("drain_steps", 32'(en_cnt), 32'd4);

    // Cycle counter saturation while stalled.
    issue_cmd(1, 0, 0);
    repeat (135) @(negedge clk);
    chk("sat_cyc", 32'({busy, cyc_count}), 32'({1'b1, 7'd127}));
    push_bytes(1, 8'h77);
    wait_done(10);
    chk("sat_cyc_hold", 32'(cyc_count), 32'd127);
    dec_byte_req = 1'b0;

    // Reset in the middle of a command with two bytes buffered.
    push_bytes(2, 8'h60);
    issue_cmd(10, 1, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'({cmd_ready, src_ready}), 32'b11);
    chk("mid_rst_outs", 32'({busy, done, dec_en, dec_n_bin, dec_bypass, bin_num}), 32'd0);
    chk("mid_rst_byte_cyc", 32'({dec_byte, cyc_count}), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({done, busy, dec_en, src_ready}), 32'b0001);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
